// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Program sequencer for the single-issue datapath. Owns the program counter,
// fetches one op at a time from instruction memory over a req/ack handshake,
// holds the op for the decoder until the datapath signals completion, then
// resolves BZ/BNZ/JMP/JMR and selects the next fetch address.
//
// Ports:
//   i_clk, i_reset        clock; synchronous active-high reset
//   o_imem_req            fetch request, held until acknowledged
//   o_imem_addr           fetch address (equals pc)
//   i_imem_ack            memory acknowledge, i_imem_data valid same cycle
//   i_imem_data           fetched op
//   o_op, o_op_valid      registered current op; pulse on a newly loaded op
//   i_exec_done           datapath finished the current op (pulse)
//   i_branch_en           current op is a control-transfer op
//   i_branch_type         00 BZ, 01 BNZ, 10 JMP, 11 JMR
//   i_zero_flag           ALU zero result for the current op
//   i_branch_offset       signed pc-relative offset
//   i_jmr_target          absolute target for JMR
//   i_halt                stop after the current op (sampled with exec_done)
//   o_pc                  address of the current op
//   o_running             low only when halted
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int OP_W     = 32,
    parameter int RESET_PC = 0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    output logic                     o_imem_req,
    output logic [ADDR_W-1:0]        o_imem_addr,
    input  logic                     i_imem_ack,
    input  logic [OP_W-1:0]          i_imem_data,
    output logic [OP_W-1:0]          o_op,
    output logic                     o_op_valid,
    input  logic                     i_exec_done,
    input  logic                     i_branch_en,
    input  logic [1:0]               i_branch_type,
    input  logic                     i_zero_flag,
    input  logic signed [15:0]       i_branch_offset,
    input  logic [ADDR_W-1:0]        i_jmr_target,
    input  logic                     i_halt,
    output logic [ADDR_W-1:0]        o_pc,
    output logic                     o_running
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXECUTE = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    // Offset arithmetic is done at least 16 bits wide so the offset is
    // sign-extended correctly, then truncated back to the address width.
    localparam int SUM_W = (ADDR_W > 16) ? ADDR_W : 16;

    localparam logic [1:0] BT_BZ  = 2'b00;
    localparam logic [1:0] BT_BNZ = 2'b01;
    localparam logic [1:0] BT_JMP = 2'b10;
    localparam logic [1:0] BT_JMR = 2'b11;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
    logic [OP_W-1:0]     r_op, w_op_nxt;
    logic                r_op_valid, w_op_valid_nxt;
    logic                r_first;
    logic                w_req;
    logic                w_take;
    logic [ADDR_W-1:0]   w_seq_pc;
    logic [ADDR_W-1:0]   w_rel_pc;
    logic [ADDR_W-1:0]   w_target;

    // Wrapping pc + signed offset.
    function automatic logic [ADDR_W-1:0] pc_add(
        input logic [ADDR_W-1:0] base,
        input logic signed [15:0] off
    );
        logic signed [SUM_W-1:0] base_ext;
        logic signed [SUM_W-1:0] off_ext;
        logic signed [SUM_W-1:0] sum;
        base_ext = SUM_W'(base);
        off_ext  = SUM_W'(off);
        sum      = base_ext + off_ext;
        return sum[ADDR_W-1:0];
    endfunction

    // Branch resolution (branch_type is meaningless without branch_en).
    always_comb begin
        w_seq_pc = r_pc + ADDR_W'(1);
        w_rel_pc = pc_add(r_pc, i_branch_offset);
        w_take   = 1'b0;
        case (i_branch_type)
            BT_BZ:   w_take = i_zero_flag;
            BT_BNZ:  w_take = ~i_zero_flag;
            BT_JMP:  w_take = 1'b1;
            default: w_take = 1'b0;
        endcase
        if (!i_branch_en) begin
            w_target = w_seq_pc;
        end else if (i_branch_type == BT_JMR) begin
            w_target = i_jmr_target;
        end else if (w_take) begin
            w_target = w_rel_pc;
        end else begin
            w_target = w_seq_pc;
        end
    end

    // Next-state / outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_op_nxt       = r_op;
        w_op_valid_nxt = 1'b0;
        w_req          = 1'b0;
        case (r_state)
            S_FETCH: begin
                // The cycle right after reset never requests.
                w_req = ~r_first;
                if (w_req && i_imem_ack) begin
                    w_op_nxt       = i_imem_data;
                    w_op_valid_nxt = 1'b1;
                    w_state_nxt    = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (i_exec_done) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = i_halt ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_FETCH;
            r_pc       <= ADDR_W'(RESET_PC);
            r_op       <= '0;
            r_op_valid <= 1'b0;
            r_first    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_op       <= w_op_nxt;
            r_op_valid <= w_op_valid_nxt;
            r_first    <= 1'b0;
        end
    end

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_op        = r_op;
    assign o_op_valid  = r_op_valid;
    assign o_pc        = r_pc;
    assign o_running   = (r_state != S_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. Inputs are driven and outputs sampled on
// the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic               clk = 1'b0;
    logic               reset;
    logic               imem_req;
    logic [7:0]         imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_data;
    logic [31:0]        op;
    logic               op_valid;
    logic               exec_done;
    logic               branch_en;
    logic [1:0]         branch_type;
    logic               zero_flag;
    logic signed [15:0] branch_offset;
    logic [7:0]         jmr_target;
    logic               halt;
    logic [7:0]         pc;
    logic               running;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_sequencer #(
        .ADDR_W   (8),
        .OP_W     (32),
        .RESET_PC (0)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_ack      (imem_ack),
        .i_imem_data     (imem_data),
        .o_op            (op),
        .o_op_valid      (op_valid),
        .i_exec_done     (exec_done),
        .i_branch_en     (branch_en),
        .i_branch_type   (branch_type),
        .i_zero_flag     (zero_flag),
        .i_branch_offset (branch_offset),
        .i_jmr_target    (jmr_target),
        .i_halt          (halt),
        .o_pc            (pc),
        .o_running       (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Fetch at address a with `waits` unacknowledged request cycles first.
    task automatic do_fetch(input logic [7:0] a, input int waits, input logic [31:0] d);
        for (int w = 0; w < waits; w++) begin
            check("req_wait", 32'(imem_req), 32'd1);
            check("addr_wait", 32'(imem_addr), 32'(a));
            check("no_valid_wait", 32'(op_valid), 32'd0);
            step();
        end
        check("req", 32'(imem_req), 32'd1);
        check("addr", 32'(imem_addr), 32'(a));
        imem_ack  = 1'b1;
        imem_data = d;
        step();
        imem_ack  = 1'b0;
        imem_data = 32'h5555_AAAA;
        check("op_valid", 32'(op_valid), 32'd1);
        check("op", op, d);
        check("pc_exec", 32'(pc), 32'(a));
        check("req_drop", 32'(imem_req), 32'd0);
    endtask

    task automatic do_exec(input logic ben, input logic [1:0] bt, input logic z,
                           input logic [15:0] off, input logic [7:0] tgt, input logic h);
        exec_done     = 1'b1;
        branch_en     = ben;
        branch_type   = bt;
        zero_flag     = z;
        branch_offset = off;
        jmr_target    = tgt;
        halt          = h;
        step();
        exec_done     = 1'b0;
        branch_en     = 1'b0;
        branch_type   = 2'b00;
        zero_flag     = 1'b0;
        branch_offset = 16'sd0;
        jmr_target    = 8'd0;
        halt          = 1'b0;
    endtask

    task automatic seq_exec();
        do_exec(1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0);
    endtask

    task automatic jmr_to(input logic [7:0] t);
        do_exec(1'b1, 2'b11, 1'b0, 16'h0000, t, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_data = '0; exec_done = 1'b0;
        branch_en = 1'b0; branch_type = 2'b00; zero_flag = 1'b0;
        branch_offset = 16'sd0; jmr_target = 8'd0; halt = 1'b0;
        @(negedge clk);
        step();
        step();

        // Reset state; this is also the first cycle out of reset.
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_op", op, 32'd0);
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_running", 32'(running), 32'd1);
        reset = 1'b0;
        step();

        // Zero-wait memory, exec_done in first EXECUTE cycle.
        for (int i = 0; i < 4; i++) begin
            do_fetch(8'(i), 0, 32'hA000_0000 + 32'(i));
            seq_exec();
        end
        do_fetch(8'd4, 0, 32'hA000_0004);
        seq_exec();

        // Delayed ack at pc 5, then a spurious ack in EXECUTE.
        do_fetch(8'd5, 3, 32'hB5B5_0005);
        imem_ack  = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        step();
        imem_ack  = 1'b0;
        check("spur_op", op, 32'hB5B5_0005);
        check("spur_valid", 32'(op_valid), 32'd0);
        check("spur_req", 32'(imem_req), 32'd0);
        check("spur_pc", 32'(pc), 32'd5);
        jmr_to(8'd10);

        // Branch resolution from pc 10.
        do_fetch(8'd10, 0, 32'h0000_0010);
        do_exec(1'b1, 2'b00, 1'b1, 16'h0004, 8'h00, 1'b0);   // BZ taken
        do_fetch(8'd14, 0, 32'h0000_0014);
        jmr_to(8'd10);
        do_fetch(8'd10, 0, 32'h0000_0010);
        do_exec(1'b1, 2'b00, 1'b0, 16'h0004, 8'h00, 1'b0);   // BZ not taken
        do_fetch(8'd11, 0, 32'h0000_0011);
        jmr_to(8'd10);
        do_fetch(8'd10, 0, 32'h0000_0010);
        do_exec(1'b1, 2'b01, 1'b0, 16'hFFFD, 8'h00, 1'b0);   // BNZ -3 taken
        do_fetch(8'd7, 0, 32'h0000_0007);
        jmr_to(8'd10);
        do_fetch(8'd10, 0, 32'h0000_0010);
        do_exec(1'b1, 2'b01, 1'b1, 16'hFFFD, 8'h00, 1'b0);   // BNZ not taken
        do_fetch(8'd11, 0, 32'h0000_0011);
        jmr_to(8'h80);
        do_fetch(8'h80, 0, 32'h0000_0080);
        do_exec(1'b0, 2'b10, 1'b0, 16'h0032, 8'h00, 1'b0);   // type ignored
        do_fetch(8'h81, 0, 32'h0000_0081);

        // Wrap-around cases.
        jmr_to(8'hFF);
        do_fetch(8'hFF, 0, 32'h0000_00FF);
        seq_exec();
        do_fetch(8'h00, 0, 32'h0000_0000);
        do_exec(1'b1, 2'b10, 1'b0, 16'hFFFF, 8'h00, 1'b0);   // JMP -1 from 0
        do_fetch(8'hFF, 0, 32'h0000_00FF);
        jmr_to(8'd20);
        do_fetch(8'd20, 0, 32'h0000_0020);
        do_exec(1'b1, 2'b10, 1'b0, 16'h0000, 8'h00, 1'b0);   // JMP 0
        do_fetch(8'd20, 0, 32'h0000_0021);
        do_exec(1'b1, 2'b10, 1'b0, 16'h0000, 8'h00, 1'b0);
        do_fetch(8'd20, 0, 32'h0000_0022);
        do_exec(1'b1, 2'b10, 1'b0, 16'h0105, 8'h00, 1'b0);   // 20+261 -> 25
        do_fetch(8'd25, 0, 32'h0000_0025);
        jmr_to(8'd3);

        // Halt after a sequential op at pc 3.
        do_fetch(8'd3, 0, 32'h0000_0003);
        do_exec(1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b1);
        check("halt_pc", 32'(pc), 32'd4);
        check("halt_running", 32'(running), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("halt_req", 32'(imem_req), 32'd0);
            imem_ack  = 1'b1;
            exec_done = 1'b1;
            step();
        end
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        check("halt_pc_hold", 32'(pc), 32'd4);
        check("halt_op_hold", op, 32'h0000_0003);
        check("halt_still", 32'(running), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_pc", 32'(pc), 32'd0);
        check("rst2_req", 32'(imem_req), 32'd0);
        check("rst2_running", 32'(running), 32'd1);
        step();
        do_fetch(8'd0, 0, 32'hC000_0000);
        jmr_to(8'd9);

        // Reset during the second wait cycle of a fetch at pc 9.
        check("w9_req", 32'(imem_req), 32'd1);
        check("w9_addr", 32'(imem_addr), 32'd9);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst3_req", 32'(imem_req), 32'd0);
        check("rst3_pc", 32'(pc), 32'd0);
        imem_ack  = 1'b1;
        imem_data = 32'hBAD0_0009;
        step();
        imem_ack  = 1'b0;
        check("late_ack_valid", 32'(op_valid), 32'd0);
        check("late_ack_op", op, 32'd0);
        do_fetch(8'd0, 0, 32'hC000_0001);
        seq_exec();
        check("resume_addr", 32'(imem_addr), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
